// File: rtl/fp_wire.sv
// fp_wire: shared FPU record types and the fp_fma_arb state bundle.
// Provides fp_fma in/out records, arbiter defaults (LAT, DEPTH) and init constant.
package fp_wire;

    localparam int FP_FMA_ARB_LAT   = 2;
    localparam int FP_FMA_ARB_DEPTH = 2;

    typedef struct packed {
        logic fmadd;
        logic fmsub;
        logic fnmsub;
        logic fnmadd;
        logic fmul;
    } fp_operation_type;

    typedef struct packed {
        logic [63:0]      a;
        logic [63:0]      b;
        logic [63:0]      c;
        logic [9:0]       class_a;
        logic [9:0]       class_b;
        logic [9:0]       class_c;
        logic [1:0]       fmt;
        logic [2:0]       rm;
        fp_operation_type op;
    } fp_fma_in_type;

    typedef struct packed {
        logic        sig;
        logic [10:0] expo;
        logic [51:0] mant;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic        ready;
    } fp_fma_out_type;

    typedef struct packed {
        logic last_grant;
    } fp_fma_arb_reg_type;

    localparam fp_fma_arb_reg_type init_fp_fma_arb_reg = '{last_grant: 1'b1};

    function automatic logic fp_op_any(fp_operation_type op);
        return |op;
    endfunction

endpackage

// File: rtl/fp_fma_arb_fifo.sv
// fp_fma_arb_fifo: per-port result buffer holding fp_fma results plus tags.
// Ports: clock/reset, i_push/i_data/i_tag in, i_pop, o_valid/o_data/o_tag/o_count out.
module fp_fma_arb_fifo
    import fp_wire::*;
#(
    parameter int TAG_W = 4,
    parameter int DEPTH = FP_FMA_ARB_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_push,
    input  fp_fma_out_type               i_data,
    input  logic [TAG_W-1:0]             i_tag,
    input  logic                         i_pop,
    output logic                         o_valid,
    output fp_fma_out_type               o_data,
    output logic [TAG_W-1:0]             o_tag,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    fp_fma_out_type   r_data [DEPTH];
    logic [TAG_W-1:0] r_tag  [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    // explicit wrap keeps DEPTH=1 correct too
    function automatic logic [PTR_W-1:0] bump(logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign o_valid = (r_count != '0);
    assign w_push  = i_push && !w_full;
    assign w_pop   = i_pop && o_valid;
    assign o_data  = r_data[r_rd];
    assign o_tag   = r_tag[r_rd];
    assign o_count = r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push)
                r_wr <= bump(r_wr);
            if (w_pop)
                r_rd <= bump(r_rd);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_data[r_wr] <= i_data;
            r_tag[r_wr]  <= i_tag;
        end
    end

endmodule

// File: rtl/fp_fma_arb.sv
// fp_fma_arb: two-port credit-based arbiter in front of a fixed-latency fp_fma.
// Ports: clock, reset, req_valid/ready/data/tag, rsp_valid/ready/data/tag, fma_i, fma_o.
// Define FP_FMA_ARB_PRIO_EN for fixed priority (port 0 highest) instead of round-robin.
module fp_fma_arb
    import fp_wire::*;
#(
    parameter int TAG_W = 4,
    parameter int LAT   = FP_FMA_ARB_LAT,
    parameter int DEPTH = FP_FMA_ARB_DEPTH
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [1:0]                  req_valid,
    output logic [1:0]                  req_ready,
    input  fp_fma_in_type [1:0]         req_data,
    input  logic [1:0][TAG_W-1:0]       req_tag,
    output logic [1:0]                  rsp_valid,
    input  logic [1:0]                  rsp_ready,
    output fp_fma_out_type [1:0]        rsp_data,
    output logic [1:0][TAG_W-1:0]       rsp_tag,
    output fp_fma_in_type               fma_i,
    input  fp_fma_out_type              fma_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             r_sv [LAT];
    logic             r_sp [LAT];
    logic [TAG_W-1:0] r_st [LAT];

    logic [1:0][CNT_W-1:0] w_count;
    logic [1:0][CNT_W-1:0] w_used;
    logic [1:0]            w_elig;
    logic [1:0]            w_ready;
    logic [1:0]            w_fire;
    logic [1:0]            w_fvalid;
    logic [1:0]            w_push;
    logic                  w_win;
    logic                  w_issue;
    logic                  w_port;
    logic                  w_live;

`ifndef FP_FMA_ARB_PRIO_EN
    fp_fma_arb_reg_type r_arb;

    always_ff @(posedge clock) begin
        if (reset)
            r_arb <= init_fp_fma_arb_reg;
        else if (w_issue)
            r_arb.last_grant <= w_port;
    end
`endif

    // credit is derived only from registered state, so a pop or an
    // issue shows up in eligibility one cycle later
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_used[p] = w_count[p];
            for (int i = 0; i < LAT; i++)
                if (r_sv[i] && (r_sp[i] == 1'(p)))
                    w_used[p] = w_used[p] + CNT_W'(1);
            w_elig[p] = (w_used[p] < CNT_W'(DEPTH));
        end
    end

    always_comb begin
`ifdef FP_FMA_ARB_PRIO_EN
        w_win = 1'b0;
`else
        w_win = ~r_arb.last_grant;
`endif
        // a port yields only to an eligible, requesting winner;
        // its own valid never gates its ready
        w_ready = w_elig;
        if (w_elig[1] && req_valid[1] && w_win)
            w_ready[0] = 1'b0;
        if (w_elig[0] && req_valid[0] && !w_win)
            w_ready[1] = 1'b0;
        req_ready = reset ? 2'b00 : w_ready;
        w_fire    = req_valid & req_ready;
        w_issue   = |w_fire;
        w_port    = w_fire[1];
        fma_i     = '0;
        if (w_issue)
            fma_i = req_data[w_port];
        // op-less requests are consumed but never tracked
        w_live    = w_issue && fp_op_any(fma_i.op);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++)
                r_sv[i] <= 1'b0;
        end else begin
            r_sv[0] <= w_live;
            for (int i = 1; i < LAT; i++)
                r_sv[i] <= r_sv[i-1];
        end
    end

    always_ff @(posedge clock) begin
        r_sp[0] <= w_port;
        r_st[0] <= req_tag[w_port];
        for (int i = 1; i < LAT; i++) begin
            r_sp[i] <= r_sp[i-1];
            r_st[i] <= r_st[i-1];
        end
    end

    // last stage lines up with fma_o of the same op
    assign w_push[0] = r_sv[LAT-1] && !r_sp[LAT-1];
    assign w_push[1] = r_sv[LAT-1] &&  r_sp[LAT-1];

    assign rsp_valid = reset ? 2'b00 : w_fvalid;

    fp_fma_arb_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push[0]),
        .i_data  (fma_o),
        .i_tag   (r_st[LAT-1]),
        .i_pop   (rsp_valid[0] & rsp_ready[0]),
        .o_valid (w_fvalid[0]),
        .o_data  (rsp_data[0]),
        .o_tag   (rsp_tag[0]),
        .o_count (w_count[0])
    );

    fp_fma_arb_fifo #(
        .TAG_W (TAG_W),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push[1]),
        .i_data  (fma_o),
        .i_tag   (r_st[LAT-1]),
        .i_pop   (rsp_valid[1] & rsp_ready[1]),
        .o_valid (w_fvalid[1]),
        .o_data  (rsp_data[1]),
        .o_tag   (rsp_tag[1]),
        .o_count (w_count[1])
    );

endmodule

// File: tb/tb_fp_fma_arb.sv
// tb_fp_fma_arb: randomized bench for fp_fma_arb with a fixed-latency fp_fma stand-in.
// Reference model tracks per-port credits, grant order and expected results in queues.
module tb_fp_fma_arb;
    import fp_wire::*;

    localparam int TAG_W = 4;
    localparam int LAT   = 2;
    localparam int DEPTH = 2;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    fp_fma_in_type [1:0]   req_data;
    logic [1:0][TAG_W-1:0] req_tag;
    logic [1:0]            rsp_valid;
    logic [1:0]            rsp_ready;
    fp_fma_out_type [1:0]  rsp_data;
    logic [1:0][TAG_W-1:0] rsp_tag;
    fp_fma_in_type         fma_i;
    fp_fma_out_type        fma_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    fp_fma_arb #(
        .TAG_W (TAG_W),
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .fma_i     (fma_i),
        .fma_o     (fma_o)
    );

    function automatic fp_fma_out_type fma_eval(fp_fma_in_type x);
        fp_fma_out_type o;
        real a, b, c, p, r;
        logic [63:0] bits;
        a = $bitstoreal(x.a);
        b = $bitstoreal(x.b);
        c = $bitstoreal(x.c);
        p = a * b;
        if (x.op.fmadd)       r = p + c;
        else if (x.op.fmsub)  r = p - c;
        else if (x.op.fnmsub) r = c - p;
        else if (x.op.fnmadd) r = -p - c;
        else                  r = p;
        bits    = $realtobits(r);
        o.sig   = bits[63];
        o.expo  = bits[62:52];
        o.mant  = bits[51:0];
        o.fmt   = x.fmt;
        o.rm    = x.rm;
        o.ready = |x.op;
        return o;
    endfunction

    // fixed-latency datapath stand-in, deliberately never reset
    fp_fma_in_type pipe [LAT];
    always @(posedge clock) begin
        pipe[0] <= fma_i;
        for (int i = 1; i < LAT; i++)
            pipe[i] <= pipe[i-1];
    end
    always_comb fma_o = fma_eval(pipe[LAT-1]);

    function automatic fp_fma_in_type mk_op(int kind, int a, int b, int c);
        fp_fma_in_type x;
        x   = '0;
        x.a = $realtobits($itor(a));
        x.b = $realtobits($itor(b));
        x.c = $realtobits($itor(c));
        x.rm = 3'(kind);
        case (kind)
            0: x.op.fmadd  = 1'b1;
            1: x.op.fmsub  = 1'b1;
            2: x.op.fnmsub = 1'b1;
            3: x.op.fnmadd = 1'b1;
            4: x.op.fmul   = 1'b1;
            default: ;
        endcase
        return x;
    endfunction

    function automatic int rnd_val();
        return int'($urandom_range(16)) - 8;
    endfunction

    function automatic fp_fma_in_type rnd_op(int max_kind);
        return mk_op(int'($urandom_range(max_kind)), rnd_val(), rnd_val(), rnd_val());
    endfunction

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [TAG_W-1:0] tag;
        fp_fma_out_type   data;
        int               avail;
    } exp_t;

    exp_t             mq [2][$];
    logic [TAG_W-1:0] rx [2][$];
    int               grants[$];
    int               used [2];
    int               iss_cnt [2];
    logic             lg;
    int               cyc;
    int               first_rsp0;
    fp_fma_out_type   cap_data;
    logic [TAG_W-1:0] cap_tag;
    int               rsp_seen;

    // one cycle: settle, compare against the model, advance the model
    task automatic step();
        logic [1:0] elig, rdy, rv, fire;
        int win, port;
        #1;
        for (int p = 0; p < 2; p++)
            elig[p] = (used[p] < DEPTH);
`ifdef FP_FMA_ARB_PRIO_EN
        win = 0;
`else
        win = (lg == 1'b1) ? 0 : 1;
`endif
        rdy = elig;
        for (int p = 0; p < 2; p++)
            if (elig[1-p] && req_valid[1-p] && (win == 1 - p))
                rdy[p] = 1'b0;
        if (reset)
            rdy = 2'b00;
        rv = 2'b00;
        for (int p = 0; p < 2; p++)
            if (!reset && mq[p].size() > 0)
                rv[p] = (mq[p][0].avail <= cyc);
        check("req_ready", 128'(req_ready), 128'(rdy));
        check("rsp_valid", 128'(rsp_valid), 128'(rv));
        if (rsp_valid != 2'b00)
            rsp_seen++;
        if (rsp_valid[0] && first_rsp0 < 0) begin
            first_rsp0 = cyc;
            cap_data   = rsp_data[0];
            cap_tag    = rsp_tag[0];
        end
        for (int p = 0; p < 2; p++) begin
            if (rv[p]) begin
                check("rsp_tag", 128'(rsp_tag[p]), 128'(mq[p][0].tag));
                check("rsp_data", 128'(rsp_data[p]), 128'(mq[p][0].data));
                if (rsp_ready[p]) begin
                    rx[p].push_back(rsp_tag[p]);
                    void'(mq[p].pop_front());
                    used[p]--;
                end
            end
        end
        fire = req_valid & rdy;
        if (fire != 2'b00) begin
            port = fire[1] ? 1 : 0;
            check("fma_op", 128'(fma_i.op), 128'(req_data[port].op));
            check("fma_a", 128'(fma_i.a), 128'(req_data[port].a));
            lg = port[0];
            grants.push_back(port);
            iss_cnt[port]++;
            if (|req_data[port].op) begin
                mq[port].push_back('{req_tag[port], fma_eval(req_data[port]), cyc + LAT + 1});
                used[port]++;
            end
        end else begin
            check("idle_op", 128'(fma_i.op), 128'(0));
        end
        if (reset) begin
            mq[0].delete();
            mq[1].delete();
            used[0] = 0;
            used[1] = 0;
            lg = 1'b1;
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        step();
        reset     = 1'b0;
    endtask

    task automatic drain(int n);
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (n) step();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        reset      = 1'b1;
        req_valid  = 2'b00;
        rsp_ready  = 2'b00;
        req_data   = '0;
        req_tag    = '0;
        lg         = 1'b1;
        used[0]    = 0;
        used[1]    = 0;
        iss_cnt[0] = 0;
        iss_cnt[1] = 0;
        cyc        = 0;
        first_rsp0 = -1;
        rsp_seen   = 0;
        @(negedge clock);
        repeat (3) step();

        // single fmadd 1*2+3 on port 0, tag 5
        reset       = 1'b0;
        rsp_ready   = 2'b11;
        req_valid   = 2'b01;
        req_data[0] = mk_op(0, 1, 2, 3);
        req_tag[0]  = 4'd5;
        t0 = cyc;
        step();
        req_valid = 2'b00;
        for (int i = 0; i < 10 && first_rsp0 < 0; i++)
            step();
        check("first_lat", 128'(first_rsp0 - t0), 128'(LAT + 1));
        check("five_expo", 128'(cap_data.expo), 128'(11'h401));
        check("five_mant", 128'(cap_data.mant), 128'(52'h4000000000000));
        check("five_sig", 128'(cap_data.sig), 128'(0));
        check("five_tag", 128'(cap_tag), 128'(5));

        // both ports streaming tags 0..7
        do_reset();
        grants.delete();
        rx[0].delete();
        rx[1].delete();
        iss_cnt[0] = 0;
        iss_cnt[1] = 0;
        rsp_ready  = 2'b11;
        for (int i = 0; i < 40 && (iss_cnt[0] < 4 || iss_cnt[1] < 4); i++) begin
            for (int p = 0; p < 2; p++) begin
                req_tag[p]  = TAG_W'(2 * iss_cnt[p] + p);
                req_data[p] = rnd_op(4);
            end
            req_valid = {iss_cnt[1] < 4, iss_cnt[0] < 4};
            step();
        end
        drain(8);
        check("grant_cnt", 128'(grants.size() >= 4), 128'(1));
`ifdef FP_FMA_ARB_PRIO_EN
        for (int k = 0; k < 2; k++)
            check("prio_grant", 128'(grants[k]), 128'(0));
`else
        for (int k = 0; k < 4; k++)
            check("rr_grant", 128'(grants[k]), 128'(k % 2));
`endif
        for (int p = 0; p < 2; p++) begin
            check("rx_cnt", 128'(rx[p].size()), 128'(4));
            for (int k = 0; k < 4 && k < rx[p].size(); k++)
                check("rx_order", 128'(rx[p][k]), 128'(2 * k + p));
        end

        // port 1 stalled on the response side
        do_reset();
        iss_cnt[0] = 0;
        iss_cnt[1] = 0;
        rsp_ready  = 2'b01;
        req_valid  = 2'b11;
        repeat (20) begin
            req_data[0] = rnd_op(4);
            req_data[1] = rnd_op(4);
            req_tag[0]  = TAG_W'($urandom);
            req_tag[1]  = TAG_W'($urandom);
            step();
        end
        check("p1_issues", 128'(iss_cnt[1]), 128'(DEPTH));
        check("p0_thru", 128'(iss_cnt[0] >= 8), 128'(1));
        drain(10);

        // reset one cycle after an issue
        do_reset();
        rsp_ready   = 2'b11;
        req_valid   = 2'b01;
        req_data[0] = mk_op(0, 2, 2, 1);
        step();
        req_valid = 2'b00;
        rsp_seen  = 0;
        reset     = 1'b1;
        step();
        reset = 1'b0;
        repeat (LAT + 2) step();
        check("rst_no_rsp", 128'(rsp_seen), 128'(0));
        iss_cnt[0] = 0;
        iss_cnt[1] = 0;
        rsp_ready  = 2'b00;
        req_valid  = 2'b11;
        req_data[0] = rnd_op(4);
        req_data[1] = rnd_op(4);
        repeat (8) step();
        check("cred0", 128'(iss_cnt[0]), 128'(DEPTH));
        check("cred1", 128'(iss_cnt[1]), 128'(DEPTH));
        drain(10);

        // random traffic with occasional reset and op-less requests
        repeat (1500) begin
            reset     = ($urandom_range(199) == 0);
            req_valid = 2'($urandom);
            rsp_ready = {$urandom_range(9) < 7, $urandom_range(9) < 7};
            for (int p = 0; p < 2; p++) begin
                req_data[p] = rnd_op(5);
                req_tag[p]  = TAG_W'($urandom);
            end
            step();
        end
        reset = 1'b0;
        drain(20);
        check("drained", 128'(mq[0].size() + mq[1].size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_fma_arb.md
FP_FMA_ARB -- requirements
Module: fp_fma_arb

Interface
REQ-001 SHALL have parameter TAG_W, default 4, meaning requester tag width.
REQ-002 SHALL have parameter LAT, default 2, meaning fixed fp_fma issue-to-result latency in cycles.
REQ-003 SHALL have parameter DEPTH, default 2, meaning result-buffer entries per port, power of 2.
REQ-004 SHALL have port clock  in  1  single clock, all logic rising-edge.
REQ-005 SHALL have port reset  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port req_valid  in  2  per-port request valid.
REQ-007 SHALL have port req_ready  out  2  per-port request accepted.
REQ-008 SHALL have port req_data  in  2 x fp_fma_in_type  per-port operation (operands, classes, op, fmt, rm).
REQ-009 SHALL have port req_tag  in  2 x TAG_W  per-port tag.
REQ-010 SHALL have port rsp_valid  out  2  per-port result valid.
REQ-011 SHALL have port rsp_ready  in  2  per-port result accepted.
REQ-012 SHALL have port rsp_data  out  2 x fp_fma_out_type  result record.
REQ-013 SHALL have port rsp_tag  out  2 x TAG_W  tag returned with result.
REQ-014 SHALL have port fma_i  out  fp_fma_in_type  datapath operation.
REQ-015 SHALL have port fma_o  in  fp_fma_out_type  datapath result.

Function
REQ-016 Transfer on each port SHALL occur when valid and ready are both 1 in the same cycle; req_ready SHALL NOT depend on req_valid of the same port.
REQ-017 At most one request SHALL be issued per cycle; the issued operation SHALL drive fma_i in that same cycle; in idle cycles all fma_i.op bits SHALL be 0.
REQ-018 A port SHALL be eligible only if credit[p] > 0; credit[p] = DEPTH minus (in-flight results for p plus occupied buffer entries for p).
REQ-019 Arbitration SHALL be round-robin: last_grant toggles to the granted port; with both eligible and valid, the port other than last_grant wins; last_grant reset value 1, so port 0 wins first.
REQ-020 A LAT-deep shift register SHALL carry {valid, port, tag} per issued op; its output stage SHALL align with fma_o of the same op.
REQ-021 When the shift register output is valid, fma_o and tag SHALL be written into that port's FIFO in the same cycle; overflow is impossible by REQ-018.
REQ-022 rsp_valid[p] SHALL equal FIFO p not-empty; pop on rsp_valid & rsp_ready; results SHALL return in issue order per port.
REQ-023 Simultaneous push and pop on one FIFO SHALL leave occupancy unchanged; credit SHALL update the cycle after a pop, never combinationally.
REQ-024 Pointers SHALL wrap modulo DEPTH; full when count == DEPTH, empty when count == 0.
REQ-025 A stalled port (rsp_ready=0, credit 0) SHALL NOT block issue from the other port.
REQ-026 Ops with no fp_fma op bit set SHALL be accepted and dropped with no result and no credit consumed.

Reset
REQ-027 During reset: req_ready=0, rsp_valid=0, fma_i.op=0, shift register invalid, FIFOs empty, credits=DEPTH, last_grant=1.
REQ-028 Reset mid-operation SHALL discard all in-flight and buffered results; fma_o.ready in the following LAT cycles SHALL be ignored.

Configuration
REQ-029 With FP_FMA_ARB_PRIO_EN defined, arbitration SHALL be fixed priority with port 0 highest and last_grant removed; without it, round-robin per REQ-019.

Structure
REQ-030 fp_fma_arb_reg_type, its init constant and DEPTH/LAT defaults SHALL live in fp_wire.
REQ-031 Per-port result buffering SHALL be one sub-module fp_fma_arb_fifo instantiated twice.

Verification
REQ-032 Port 0 fmadd 1.0*2.0+3.0, tag 5, rsp_ready=1 -> rsp_valid[0] LAT+1 cycles later, mant/expo for 5.0, tag 5.
REQ-033 Both ports valid every cycle, tags 0..7 -> grants alternate 0,1,0,1; each port receives its tags in order.
REQ-034 rsp_ready[1]=0, port 1 issuing continuously -> exactly DEPTH port-1 issues, then req_ready[1]=0; port 0 throughput unaffected.
REQ-035 Reset asserted one cycle after an issue -> no rsp_valid in the next LAT+2 cycles; credits back to DEPTH.
REQ-036 FP_FMA_ARB_PRIO_EN defined, both valid continuously -> port 0 always granted, port 1 starves.
